// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
//   Shared Wishbone definitions for the subsystem.
//
//   Contents:
//     WB_ADR_W / WB_DAT_W / WB_SEL_W : default bus widths, reused by
//                                      wishbone_if, wb_cmd_master and xpm_ram
//     wb_cmd_t          : one bus command (we, adr, dat, sel)
//     wb_rsp_t          : one bus response (dat, err)
//     wb_master_state_e : state encoding of the command master FSM
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_ADR_W = 20;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = WB_DAT_W / 8;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_cmd_t;

    typedef struct packed {
        logic [WB_DAT_W-1:0] dat;
        logic                err;
    } wb_rsp_t;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_BUS  = 2'd1,
        WB_RESP = 2'd2
    } wb_master_state_e;

endpackage : wb_pkg

// File: rtl/wishbone_if.sv
// ---------------------------------------------------------------------------
// wishbone_if
//   Wishbone classic bus bundle (single master, single slave view).
//
//   Parameters:
//     ADR_W : word address width
//     DAT_W : data width, SEL_W = DAT_W/8 byte enables
//
//   Signals:
//     cyc, stb, we, adr, dat_m2s, sel : driven by the master
//     ack, err, dat_s2m               : driven by the slave
//
//   Modports: master, slave
// ---------------------------------------------------------------------------
interface wishbone_if #(
    parameter int ADR_W = wb_pkg::WB_ADR_W,
    parameter int DAT_W = wb_pkg::WB_DAT_W
) ();

    localparam int SEL_W = DAT_W / 8;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_m2s;
    logic [SEL_W-1:0] sel;
    logic             ack;
    logic             err;
    logic [DAT_W-1:0] dat_s2m;

    modport master (
        output cyc, stb, we, adr, dat_m2s, sel,
        input  ack, err, dat_s2m
    );

    modport slave (
        input  cyc, stb, we, adr, dat_m2s, sel,
        output ack, err, dat_s2m
    );

endinterface : wishbone_if

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//   Wishbone classic master. Accepts one command on a valid/ready stream,
//   runs a single read or write bus cycle, and returns {data, err} on a
//   valid/ready response stream. Exactly one transaction is in flight.
//
//   Handshake rule (both streams): a transfer happens on a rising clock edge
//   where valid and ready are both high; the producer keeps valid and its
//   payload stable until that edge; ready never depends combinationally on
//   valid.
//
//   Parameters:
//     ADR_W       : word address width (must match wishbone_if)
//     DAT_W       : data width, SEL_W = DAT_W/8
//     TIMEOUT_CYC : bus cycles without ack/err before aborting
//                   (only with WB_CMD_MASTER_TIMEOUT_EN)
//
//   Ports:
//     clk_i, rst_ni           : clock, asynchronous active-low reset
//     cmd_valid_i/cmd_ready_o : command handshake
//     cmd_we_i, cmd_adr_i,
//     cmd_dat_i, cmd_sel_i    : command payload
//     rsp_valid_o/rsp_ready_i : response handshake
//     rsp_dat_o, rsp_err_o    : response payload (dat is 0 for writes/errors)
//     wb                      : wishbone_if.master
//
//   Configuration macro:
//     WB_CMD_MASTER_TIMEOUT_EN : when defined, a silent slave is aborted
//                                after TIMEOUT_CYC bus cycles with err = 1.
//                                When undefined, the bus cycle waits forever.
// ---------------------------------------------------------------------------
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int ADR_W       = WB_ADR_W,
    parameter int DAT_W       = WB_DAT_W,
    parameter int TIMEOUT_CYC = 255,
    localparam int SEL_W      = DAT_W / 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [DAT_W-1:0] cmd_dat_i,
    input  logic [SEL_W-1:0] cmd_sel_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DAT_W-1:0] rsp_dat_o,
    output logic             rsp_err_o,

    wishbone_if.master       wb
);

    // The timeout limit must allow at least one bus cycle.
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT_CYC must be at least 1");
    end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    // Counter is never narrower than 8 bits.
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_to_cnt;
`endif

    wb_master_state_e r_state;

    // Registered outputs: every port below comes straight from a flop.
    logic             r_cmd_ready;
    logic             r_cyc;
    logic             r_we;
    logic [ADR_W-1:0] r_adr;
    logic [DAT_W-1:0] r_dat;
    logic [SEL_W-1:0] r_sel;
    logic             r_rsp_valid;
    logic [DAT_W-1:0] r_rsp_dat;
    logic             r_rsp_err;

    // -----------------------------------------------------------------------
    // Control FSM: IDLE -> BUS -> RESP -> IDLE
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= WB_IDLE;
            r_cmd_ready <= 1'b1;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                WB_IDLE: begin
                    if (cmd_valid_i && r_cmd_ready) begin
                        r_we        <= cmd_we_i;
                        r_adr       <= cmd_adr_i;
                        r_dat       <= cmd_dat_i;
                        r_sel       <= cmd_sel_i;
                        r_cyc       <= 1'b1;
                        r_cmd_ready <= 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                        r_to_cnt    <= '0;
`endif
                        r_state     <= WB_BUS;
                    end
                end

                WB_BUS: begin
                    // err outranks ack; ack outranks the timeout.
                    if (wb.err) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= WB_RESP;
                    end else if (wb.ack) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= r_we ? '0 : wb.dat_s2m;
                        r_rsp_err   <= 1'b0;
                        r_state     <= WB_RESP;
                    end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    // Compare against LAST so that cyc is high for exactly
                    // TIMEOUT_CYC cycles before the abort.
                    else if (r_to_cnt == CNT_LAST) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= WB_RESP;
                    end else begin
                        r_to_cnt    <= r_to_cnt + 1'b1;
                    end
`endif
                end

                WB_RESP: begin
                    // Payload holds until the consumer takes it.
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= WB_IDLE;
                    end
                end

                default: begin
                    r_cyc       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= WB_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;

    // stb always follows cyc: one single-beat cycle per command.
    assign wb.cyc     = r_cyc;
    assign wb.stb     = r_cyc;
    assign wb.we      = r_we;
    assign wb.adr     = r_adr;
    assign wb.dat_m2s = r_dat;
    assign wb.sel     = r_sel;

endmodule : wb_cmd_master

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_master
//   Self-checking bench for wb_cmd_master with a behavioural RAM slave that
//   can answer zero-wait, registered-ack, error, or not at all.
// ---------------------------------------------------------------------------
module tb_wb_cmd_master;
    import wb_pkg::*;

    localparam int ADR_W = 20;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    localparam int TO    = 8;

    localparam int M_ZW  = 0;  // zero-wait RAM
    localparam int M_REG = 1;  // registered-ack RAM
    localparam int M_ERR = 2;  // err + ack together
    localparam int M_SIL = 3;  // never answers

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // ---------------- DUT ----------------
    logic             cmd_valid = 1'b0;
    logic             cmd_ready_o;
    logic             cmd_we  = 1'b0;
    logic [ADR_W-1:0] cmd_adr = '0;
    logic [DAT_W-1:0] cmd_dat = '0;
    logic [SEL_W-1:0] cmd_sel = '0;
    logic             rsp_valid_o;
    logic             rsp_ready = 1'b0;
    logic [DAT_W-1:0] rsp_dat_o;
    logic             rsp_err_o;

    wishbone_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) wb ();

    wb_cmd_master #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT_CYC(TO)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wb          (wb)
    );

    // ---------------- slave model ----------------
    int          slave_mode = M_ZW;
    logic        stray_ack  = 1'b0;
    logic        stray_err  = 1'b0;
    logic        ack_d;
    logic [31:0] ram [0:255];

    always_ff @(posedge clk) begin
        if (!rst_n) ack_d <= 1'b0;
        else        ack_d <= (slave_mode == M_REG) && wb.cyc && wb.stb && !ack_d;
    end

    always_comb begin
        wb.ack     = stray_ack && !wb.cyc;
        wb.err     = stray_err && !wb.cyc;
        wb.dat_s2m = ram[wb.adr[7:0]];
        if (wb.cyc && wb.stb) begin
            case (slave_mode)
                M_ZW:    wb.ack = 1'b1;
                M_REG:   wb.ack = ack_d;
                M_ERR:   begin wb.ack = 1'b1; wb.err = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
        end else if (wb.cyc && wb.stb && wb.ack && !wb.err && wb.we) begin
            for (int b = 0; b < SEL_W; b++)
                if (wb.sel[b]) ram[wb.adr[7:0]][8*b +: 8] <= wb.dat_m2s[8*b +: 8];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0]    model_mem [0:255];
    logic [DAT_W:0] exp_q[$];   // {err, dat}
    int checks   = 0;
    int failures = 0;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
    endtask

    task automatic report_and_finish();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Runs one transaction; must be called right after a falling edge.
    task automatic run_txn(input logic we, input logic [ADR_W-1:0] adr,
                           input logic [DAT_W-1:0] dat, input logic [SEL_W-1:0] sel,
                           input int mode, input int hold, input string tag,
                           output logic [DAT_W-1:0] rdat);
        logic [DAT_W:0] exp;
        int n;
        int lat;
        int exp_lat;
        if (mode == M_ERR) begin
            exp = {1'b1, 32'h0};
        end else if (we) begin
            exp = {1'b0, 32'h0};
            for (int b = 0; b < SEL_W; b++)
                if (sel[b]) model_mem[adr[7:0]][8*b +: 8] = dat[8*b +: 8];
        end else begin
            exp = {1'b0, model_mem[adr[7:0]]};
        end
        exp_q.push_back(exp);
        exp_lat = (mode == M_REG) ? 3 : 2;

        slave_mode = mode;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        n = 0;
        while (!cmd_ready_o && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: cmd_ready_o=%b required 1 within 20 cycles", tag, cmd_ready_o);
            report_and_finish();
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;

        checks++;
        if ({wb.cyc, wb.stb, wb.we, wb.adr, wb.dat_m2s, wb.sel} !== {2'b11, we, adr, dat, sel}) begin
            failures++;
            $display("FAIL %s bus: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h required 1 1 %b %h %h %h",
                     tag, wb.cyc, wb.stb, wb.we, wb.adr, wb.dat_m2s, wb.sel, we, adr, dat, sel);
        end

        lat = 1;
        while (!rsp_valid_o && lat < 50) begin @(negedge clk); lat++; end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles required %0d", tag, lat, exp_lat);
        end

        exp = exp_q.pop_front();
        checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_dat_o} !== {1'b1, exp}) begin
            failures++;
            $display("FAIL %s rsp: valid=%b err=%b dat=%h required 1 %b %h",
                     tag, rsp_valid_o, rsp_err_o, rsp_dat_o, exp[DAT_W], exp[DAT_W-1:0]);
        end
        checks++;
        if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || cmd_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL %s resp_phase: cyc=%b stb=%b cmd_ready=%b required 0 0 0",
                     tag, wb.cyc, wb.stb, cmd_ready_o);
        end
        rdat = rsp_dat_o;

        // Hold off the consumer; stray ack/err must not disturb anything.
        for (int i = 0; i < hold; i++) begin
            stray_ack = 1'($urandom_range(0, 1));
            stray_err = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({rsp_valid_o, rsp_err_o, rsp_dat_o} !== {1'b1, exp} ||
                cmd_ready_o !== 1'b0 || wb.cyc !== 1'b0) begin
                failures++;
                $display("FAIL %s hold%0d: valid=%b err=%b dat=%h cmd_ready=%b cyc=%b required 1 %b %h 0 0",
                         tag, i, rsp_valid_o, rsp_err_o, rsp_dat_o, cmd_ready_o, wb.cyc,
                         exp[DAT_W], exp[DAT_W-1:0]);
            end
        end
        stray_ack = 1'b0;
        stray_err = 1'b0;

        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || wb.cyc !== 1'b0) begin
            failures++;
            $display("FAIL %s release: valid=%b cmd_ready=%b cyc=%b required 0 1 0",
                     tag, rsp_valid_o, cmd_ready_o, wb.cyc);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_dat_o} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL reset_stream: cmd_ready=%b valid=%b err=%b dat=%h required 1 0 0 0",
                     cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_dat_o);
        end
        checks++;
        if ({wb.cyc, wb.stb, wb.we, wb.adr, wb.dat_m2s, wb.sel} !== '0) begin
            failures++;
            $display("FAIL reset_bus: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h required all 0",
                     wb.cyc, wb.stb, wb.we, wb.adr, wb.dat_m2s, wb.sel);
        end
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        checks++;
        if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: cmd_ready=%b valid=%b required 1 0", cmd_ready_o, rsp_valid_o);
        end
    endtask

    task automatic test_ram_basic();
        logic [DAT_W-1:0] r;
        run_txn(1'b1, 20'h00010, 32'hDEADBEEF, 4'b1111, M_ZW, 0, "wr_beef", r);
        run_txn(1'b0, 20'h00010, 32'h0, 4'b1111, M_ZW, 0, "rd_beef", r);
        checks++;
        if (r !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_beef_const: got %h required deadbeef", r);
        end
    endtask

    task automatic test_byte_enable();
        logic [DAT_W-1:0] r;
        run_txn(1'b1, 20'h00010, 32'h000000AA, 4'b0001, M_REG, 0, "wr_byte", r);
        run_txn(1'b0, 20'h00010, 32'h0, 4'b1111, M_REG, 0, "rd_byte", r);
        checks++;
        if (r !== 32'hDEADBEAA) begin
            failures++;
            $display("FAIL rd_byte_const: got %h required deadbeaa", r);
        end
    endtask

    task automatic test_error();
        logic [DAT_W-1:0] r;
        run_txn(1'b1, 20'h00010, $urandom, 4'b1111, M_ERR, 0, "err_wr", r);
        run_txn(1'b0, 20'h00010, 32'h0, 4'b1111, M_ERR, 0, "err_rd", r);
        run_txn(1'b0, 20'h00010, 32'h0, 4'b1111, M_ZW, 0, "err_after", r);
    endtask

    task automatic test_backpressure();
        logic [DAT_W-1:0] r;
        run_txn(1'b0, 20'h00010, 32'h0, 4'b1111, M_ZW, 10, "bp_rd", r);
        run_txn(1'b1, 20'h00022, 32'h12345678, 4'b1010, M_REG, 10, "bp_wr", r);
    endtask

    task automatic test_back_to_back();
        logic [DAT_W-1:0] r;
        int t0;
        t0 = cycle_cnt;
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, 20'(8'h40 + i), $urandom, 4'b1111, M_ZW, 0, "b2b", r);
        checks++;
        if (cycle_cnt - t0 != 12) begin
            failures++;
            $display("FAIL b2b_throughput: got %0d cycles for 4 txns required 12", cycle_cnt - t0);
        end
    endtask

    task automatic test_random();
        logic [DAT_W-1:0] r;
        int mode;
        int gap;
        for (int k = 0; k < 40; k++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                stray_ack = 1'($urandom_range(0, 1));
                stray_err = 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++;
                if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || wb.cyc !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_idle: cmd_ready=%b valid=%b cyc=%b required 1 0 0",
                             cmd_ready_o, rsp_valid_o, wb.cyc);
                end
            end
            stray_ack = 1'b0;
            stray_err = 1'b0;
            mode = ($urandom_range(0, 7) == 0) ? M_ERR : $urandom_range(0, 1);
            run_txn(1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)), $urandom,
                    4'($urandom_range(0, 15)), mode, $urandom_range(0, 3), "rnd", r);
        end
    endtask

    // Starts a command towards the silent slave; returns after cyc rises.
    task automatic start_silent();
        slave_mode = M_SIL;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 20'h00033; cmd_sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int cyc_hi;
        int n;
        start_silent();
        cyc_hi = 0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        n = 0;
        while (wb.cyc && n < 50) begin cyc_hi++; @(negedge clk); n++; end
        checks++;
        if (cyc_hi != TO) begin
            failures++;
            $display("FAIL timeout_len: cyc high %0d cycles required %0d", cyc_hi, TO);
        end
        checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_dat_o} !== {2'b11, 32'h0}) begin
            failures++;
            $display("FAIL timeout_rsp: valid=%b err=%b dat=%h required 1 1 0",
                     rsp_valid_o, rsp_err_o, rsp_dat_o);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_release: valid=%b cmd_ready=%b required 0 1", rsp_valid_o, cmd_ready_o);
        end
`else
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (wb.cyc === 1'b1 && rsp_valid_o === 1'b0) cyc_hi++;
            @(negedge clk);
        end
        checks++;
        if (cyc_hi != 100) begin
            failures++;
            $display("FAIL no_timeout: cyc high without response %0d cycles required 100", cyc_hi);
        end
        checks++;
        if (wb.cyc !== 1'b1 || rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL no_timeout_end: cyc=%b valid=%b required 1 0", wb.cyc, rsp_valid_o);
        end
`endif
    endtask

    task automatic test_reset_mid_cycle();
        if (wb.cyc !== 1'b1) begin
            start_silent();
            repeat (3) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_drop: cyc=%b stb=%b valid=%b required 0 0 0",
                     wb.cyc, wb.stb, rsp_valid_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        slave_mode = M_ZW;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || wb.cyc !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_after%0d: valid=%b cmd_ready=%b cyc=%b required 0 1 0",
                         i, rsp_valid_o, cmd_ready_o, wb.cyc);
            end
        end
    endtask

    task automatic test_after_reset();
        logic [DAT_W-1:0] r;
        run_txn(1'b0, 20'h00010, 32'h0, 4'b1111, M_ZW, 0, "post_rst_rd", r);
        run_txn(1'b1, 20'h00011, 32'hCAFEF00D, 4'b0110, M_REG, 1, "post_rst_wr", r);
        run_txn(1'b0, 20'h00011, 32'h0, 4'b1111, M_ZW, 0, "post_rst_rd2", r);
    endtask

    initial begin
        test_reset();
        test_ram_basic();
        test_byte_enable();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_cycle();
        test_after_reset();
        report_and_finish();
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        report_and_finish();
    end

endmodule : tb_wb_cmd_master
